// File: rtl/decode_cycle.sv
// Decode stage: instruction decode, 32x32 register file with write-read
// bypass, and the ID/EX pipeline register with flush-to-bubble.
module decode_cycle #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE
);

  localparam int unsigned IMMW = 12;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [XLEN-1:0] rf [NREGS];

  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic [4:0]      rd_d;

  logic            reg_write_d;
  logic [1:0]      imm_src_d;
  logic            alu_src_d;
  logic            mem_write_d;
  logic [1:0]      result_src_d;
  logic            branch_d;
  logic [1:0]      alu_op_d;
  logic            jump_d;
  logic [2:0]      alu_ctl_d;
  logic [XLEN-1:0] imm_ext_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic            wr_en;

  assign op        = InstrD[6:0];
  assign rd_d      = InstrD[11:7];
  assign funct3    = InstrD[14:12];
  assign Rs1D      = InstrD[19:15];
  assign Rs2D      = InstrD[24:20];
  assign funct7_b5 = InstrD[30];
  assign wr_en     = RegWriteW && (RdW != 5'd0);

  // Register file: cleared on reset, x0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[RdW] <= ResultW;
    end
  end

  // Read ports: x0 reads zero, same-cycle writeback is forwarded.
  always_comb begin
    rd1_d = rf[Rs1D];
    rd2_d = rf[Rs2D];
    if (wr_en && (RdW == Rs1D)) rd1_d = ResultW;
    if (wr_en && (RdW == Rs2D)) rd2_d = ResultW;
    if (Rs1D == 5'd0) rd1_d = '0;
    if (Rs2D == 5'd0) rd2_d = '0;
  end

  // Main decoder: unknown opcodes decode to an all-zero control word.
  always_comb begin
    reg_write_d  = 1'b0;
    imm_src_d    = 2'b00;
    alu_src_d    = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = 2'b00;
    branch_d     = 1'b0;
    alu_op_d     = 2'b00;
    jump_d       = 1'b0;
    case (op)
      OP_LW: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b01;
      end
      OP_SW: begin
        imm_src_d   = 2'b01;
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      OP_R: begin
        reg_write_d = 1'b1;
        alu_op_d    = 2'b10;
      end
      OP_BEQ: begin
        imm_src_d = 2'b10;
        branch_d  = 1'b1;
        alu_op_d  = 2'b01;
      end
      OP_IALU: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_op_d    = 2'b10;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        imm_src_d    = 2'b11;
        result_src_d = 2'b10;
        jump_d       = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder: sub only for R-type with funct7[5] set.
  always_comb begin
    alu_ctl_d = ALU_ADD;
    case (alu_op_d)
      2'b01: alu_ctl_d = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctl_d = (op[5] && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctl_d = ALU_SLT;
          3'b110:  alu_ctl_d = ALU_OR;
          3'b111:  alu_ctl_d = ALU_AND;
          default: alu_ctl_d = ALU_ADD;
        endcase
      end
      default: alu_ctl_d = ALU_ADD;
    endcase
  end

  // Immediate extend, all forms sign-extended from InstrD[31].
  always_comb begin
    imm_ext_d = '0;
    case (imm_src_d)
      2'b00: imm_ext_d = {{(XLEN-IMMW){InstrD[31]}}, InstrD[31:20]};
      2'b01: imm_ext_d = {{(XLEN-IMMW){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10: imm_ext_d = {{(XLEN-IMMW-1){InstrD[31]}}, InstrD[31], InstrD[7],
                          InstrD[30:25], InstrD[11:8], 1'b0};
      2'b11: imm_ext_d = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                          InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext_d = '0;
    endcase
  end

  // ID/EX register: reset or flush loads a bubble.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
    end else begin
      RD1E        <= rd1_d;
      RD2E        <= rd2_d;
      ImmExtE     <= imm_ext_d;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= rd_d;
      RegWriteE   <= reg_write_d;
      MemWriteE   <= mem_write_d;
      JumpE       <= jump_d;
      BranchE     <= branch_d;
      ALUSrcE     <= alu_src_d;
      ResultSrcE  <= result_src_d;
      ALUControlE <= alu_ctl_d;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: ordered vector table, expected E-stage words
// queued at drive time and compared one cycle later.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        FlushE = 1'b0, RegWriteW = 1'b0;
  logic [4:0]  RdW = '0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pce, pc4e;
    logic [4:0]  rs1e, rs2e, rde;
    logic [9:0]  ctl;  // {regw, memw, jump, branch, alusrc, ressrc[1:0], aluctl[2:0]}
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr, pc;
    logic        r, f, w;
    logic [4:0]  rd;
    logic [31:0] res;
    exp_t        exp;
  } vec_t;

  typedef struct {
    string name;
    exp_t  exp;
  } sb_t;

  localparam logic [9:0] C_ADDI = 10'b1_0_0_0_1_00_000;
  localparam logic [9:0] C_ANDI = 10'b1_0_0_0_1_00_010;
  localparam logic [9:0] C_LW   = 10'b1_0_0_0_1_01_000;
  localparam logic [9:0] C_SW   = 10'b0_1_0_0_1_00_000;
  localparam logic [9:0] C_RADD = 10'b1_0_0_0_0_00_000;
  localparam logic [9:0] C_RSUB = 10'b1_0_0_0_0_00_001;
  localparam logic [9:0] C_RSLT = 10'b1_0_0_0_0_00_101;
  localparam logic [9:0] C_ROR  = 10'b1_0_0_0_0_00_011;
  localparam logic [9:0] C_BEQ  = 10'b0_0_0_1_0_00_001;
  localparam logic [9:0] C_JAL  = 10'b1_0_1_0_0_10_000;
  localparam logic [9:0] C_NONE = 10'b0;

  vec_t vecs[$];
  sb_t  sb[$];
  exp_t act;
  int   total = 0;
  int   bad = 0;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE)
  );

  always #5 clk = ~clk;

  assign act = {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
                RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};

  function automatic exp_t ex(logic [31:0] rd1, rd2, imm, logic [4:0] rs1, rs2, rd,
                              logic [9:0] ctl);
    exp_t e;
    e = '0;
    e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
    e.rs1e = rs1; e.rs2e = rs2; e.rde = rd; e.ctl = ctl;
    return e;
  endfunction

  function automatic void add(string n, logic [31:0] instr, pc, logic r, f, w,
                              logic [4:0] rd, logic [31:0] res, exp_t e);
    vec_t v;
    if (r || f) e = '0;
    else begin
      e.pce  = pc;
      e.pc4e = pc + 32'd4;
    end
    v.name = n; v.instr = instr; v.pc = pc; v.r = r; v.f = f; v.w = w;
    v.rd = rd; v.res = res; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    sb_t s;
    logic [31:0] ins;

    // Two reset cycles, then read every register back through an R-type.
    add("reset0", 32'h00700293, 32'h0, 1, 0, 0, 5'd0, 32'h0, '0);
    add("reset1", 32'h0082A303, 32'h4, 1, 0, 0, 5'd0, 32'h0, '0);
    for (int i = 1; i < 32; i++) begin
      ins = {7'b0, 5'(i), 5'(i), 3'b000, 5'd0, 7'b0110011};
      add($sformatf("rst_read_x%0d", i), ins, 32'h0, 0, 0, 0, 5'd0, 32'h0,
          ex(32'h0, 32'h0, 32'(i), 5'(i), 5'(i), 5'd0, C_RADD));
    end

    add("addi",      32'h00700293, 32'h10, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h0, 32'h0, 32'd7, 5'd0, 5'd7, 5'd5, C_ADDI));
    add("lw_bypass", 32'h0082A303, 32'h14, 0, 0, 1, 5'd5, 32'hDEADBEEF,
        ex(32'hDEADBEEF, 32'h0, 32'd8, 5'd5, 5'd8, 5'd6, C_LW));
    add("lw_reread", 32'h0082A303, 32'h18, 0, 0, 0, 5'd0, 32'h0,
        ex(32'hDEADBEEF, 32'h0, 32'd8, 5'd5, 5'd8, 5'd6, C_LW));
    add("x0_write",  32'h00700293, 32'h1C, 0, 0, 1, 5'd0, 32'h55,
        ex(32'h0, 32'h0, 32'd7, 5'd0, 5'd7, 5'd5, C_ADDI));
    add("x0_read",   32'h000000B3, 32'h20, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, C_RADD));
    add("sw",        32'hFE612E23, 32'h24, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h0, 32'h0, 32'hFFFFFFFC, 5'd2, 5'd6, 5'd28, C_SW));
    add("beq",       32'hFE208CE3, 32'h28, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h0, 32'h0, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, C_BEQ));
    add("flush",     32'h00700293, 32'h2C, 0, 1, 1, 5'd7, 32'h12, '0);
    add("x7_after_flush", 32'h00700293, 32'h30, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h0, 32'h12, 32'd7, 5'd0, 5'd7, 5'd5, C_ADDI));
    add("add",       32'h00538433, 32'h34, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h12, 32'hDEADBEEF, 32'd5, 5'd7, 5'd5, 5'd8, C_RADD));
    add("sub",       32'h405384B3, 32'h38, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h12, 32'hDEADBEEF, 32'h405, 5'd7, 5'd5, 5'd9, C_RSUB));
    add("slt",       32'h0053A533, 32'h3C, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h12, 32'hDEADBEEF, 32'd5, 5'd7, 5'd5, 5'd10, C_RSLT));
    add("or",        32'h0053E5B3, 32'h40, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h12, 32'hDEADBEEF, 32'd5, 5'd7, 5'd5, 5'd11, C_ROR));
    add("andi",      32'hFFF3F613, 32'h44, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h12, 32'h0, 32'hFFFFFFFF, 5'd7, 5'd31, 5'd12, C_ANDI));
    add("addi_b30",  32'h40038693, 32'h48, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h12, 32'h0, 32'h400, 5'd7, 5'd0, 5'd13, C_ADDI));
    add("jal_pos",   32'h008000EF, 32'h4C, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h0, 32'h0, 32'd8, 5'd0, 5'd8, 5'd1, C_JAL));
    add("jal_neg",   32'hFF5FF0EF, 32'h50, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h0, 32'h0, 32'hFFFFFFF4, 5'd31, 5'd21, 5'd1, C_JAL));
    add("unknown_op", 32'h0000007F, 32'h54, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, C_NONE));
    add("rst_and_flush", 32'h00538433, 32'h58, 1, 1, 0, 5'd0, 32'h0, '0);
    add("read_after_rst", 32'h00538433, 32'h5C, 0, 0, 0, 5'd0, 32'h0,
        ex(32'h0, 32'h0, 32'd5, 5'd7, 5'd5, 5'd8, C_RADD));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].r; FlushE = vecs[i].f; InstrD = vecs[i].instr;
      PCD = vecs[i].pc; PCPlus4D = vecs[i].pc + 32'd4;
      RegWriteW = vecs[i].w; RdW = vecs[i].rd; ResultW = vecs[i].res;
      s.name = vecs[i].name; s.exp = vecs[i].exp;
      sb.push_back(s);
      #1;
      if (!vecs[i].r && !vecs[i].f) begin
        total++;
        if ({Rs1D, Rs2D} !== {vecs[i].exp.rs1e, vecs[i].exp.rs2e}) begin
          bad++;
          $display("FAIL %s_rsD: got rs1=%0d rs2=%0d want rs1=%0d rs2=%0d", vecs[i].name,
                   Rs1D, Rs2D, vecs[i].exp.rs1e, vecs[i].exp.rs2e);
        end
      end
      @(posedge clk);
      #1;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL %s: scoreboard empty, got %h want an entry", vecs[i].name, act);
      end else begin
        s = sb.pop_front();
        if (act !== s.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", s.name, act, s.exp);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Decode stage of the 5-stage pipelined RISC-V core. Consumer end of the IF/ID interface that the fetch stage drives.
- Takes InstrD, PCD and PCPlus4D, decodes the instruction and reads the 32x32 register file.
- Accepts the writeback port from the W stage.
- Registers all results into the ID/EX pipeline register, which has a flush input for branch/jump and load-use bubbles.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register-file depth. x0 is hardwired to zero.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- InstrD  input  32  instruction from the IF/ID register
- PCD  input  32  PC of InstrD
- PCPlus4D  input  32  PCD+4
- FlushE  input  1  when high, the ID/EX register loads a bubble
- RegWriteW  input  1  writeback enable
- RdW  input  5  writeback destination
- ResultW  input  32  writeback data
- Rs1D  output  5  InstrD[19:15], combinational, for the hazard unit
- Rs2D  output  5  InstrD[24:20], combinational
- RD1E  output  32  registered rs1 data
- RD2E  output  32  registered rs2 data
- ImmExtE  output  32  registered sign-extended immediate
- PCE  output  32  registered PCD
- PCPlus4E  output  32  registered PCPlus4D
- Rs1E  output  5  registered Rs1D
- Rs2E  output  5  registered Rs2D
- RdE  output  5  registered InstrD[11:7]
- RegWriteE  output  1  registered control
- MemWriteE  output  1  registered control
- JumpE  output  1  registered control
- BranchE  output  1  registered control
- ALUSrcE  output  1  registered control
- ResultSrcE  output  2  registered control. 00 = ALU, 01 = memory, 10 = PC+4.
- ALUControlE  output  3  registered control. 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high, on port rst. All state updates on the rising edge of clk.
- Reset:
  - All 32 register-file entries are cleared to 0.
  - Every E-stage output is 0. This is equivalent to a bubble.
- Latency: an instruction presented on InstrD appears decoded on the E outputs 1 cycle later.
- ID/EX update:
  - If rst or FlushE: every E output is 0.
  - Otherwise: every E output loads its D-side value.
  - No hold/stall input. Stalling is done upstream by holding the IF/ID register.
- Register file:
  - Write occurs when RegWriteW=1 and RdW!=0.
  - Writes to x0 are ignored. Reads of x0 always return 0.
- Write-read bypass:
  - Condition: RegWriteW=1, RdW!=0, and RdW equals Rs1D (or Rs2D) in the same cycle.
  - The read returns ResultW, so RD1E/RD2E capture the new value.
- Main decoder, by InstrD[6:0] (fields: RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump):
  - 0000011 lw: 1, 00, 1, 0, 01, 0, 00, 0.
  - 0100011 sw: 0, 01, 1, 1, xx→00, 0, 00, 0.
  - 0110011 R-type: 1, xx→00, 0, 0, 00, 0, 10, 0.
  - 1100011 beq: 0, 10, 0, 0, 00, 1, 01, 0.
  - 0010011 I-ALU: 1, 00, 1, 0, 00, 0, 10, 0.
  - 1101111 jal: 1, 11, 0, 0, 10, 0, 00, 1.
  - Any other opcode, including InstrD=0: all controls 0. A zero instruction is therefore a NOP.
- ALU decoder:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, funct3 000 → sub if op[5]=1 and funct7[5]=1, else add.
  - ALUOp 10, funct3 010 → slt.
  - ALUOp 10, funct3 110 → or.
  - ALUOp 10, funct3 111 → and.
  - ALUOp 10, other funct3 → add.
- Immediate extend. All forms are sign-extended from InstrD[31].
  - I: InstrD[31:20].
  - S: {InstrD[31:25], InstrD[11:7]}.
  - B: {InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 0}.
  - J: {InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 0}.
- Simultaneous rst and FlushE: reset wins. The result is identical in any case.
- Simultaneous FlushE and a writeback: the register-file write still occurs. Only the ID/EX contents are bubbled.

Test Plan:
- Reset: assert rst for 2 cycles with any InstrD.
  - All E outputs must be 0.
  - A subsequent read of x1..x31 must return 0.
- addi x5,x0,7 (InstrD=0x00700293, PCD=0x10).
  - After 1 cycle: RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=7, RdE=5, PCE=0x10, PCPlus4E=0x14.
- Write-read bypass:
  - Stimulus: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF in the same cycle as InstrD=0x0082A303 (lw x6,8(x5)).
  - Required: RD1E=0xDEADBEEF, ImmExtE=8, ResultSrcE=01, RdE=6.
  - Next cycle, with no write: a re-read still gives 0xDEADBEEF.
- x0 write: RegWriteW=1, RdW=0, ResultW=0x55.
  - A read of x0 (rs1=0) must give RD1E=0.
- Immediates:
  - sw x6,-4(x2) = 0xFE612E23 → MemWriteE=1, RegWriteE=0, ImmExtE=0xFFFFFFFC.
  - beq x1,x2,-8 = 0xFE208CE3 → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8.
- Flush: FlushE=1 while InstrD=0x00700293.
  - Next cycle: every E output is 0.
  - A concurrent writeback of x7=0x12 is still visible on a later read.
